// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 8-bit ALU between port 0 (control) and port 1 (data).
// Define ALU_ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module alu_arbiter #(
    parameter int W   = 8,
    parameter int OPW = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [OPW-1:0] req0_op,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [OPW-1:0] req1_op,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    output logic           rsp0_valid,
    input  logic           rsp0_ready,
    output logic           rsp1_valid,
    input  logic           rsp1_ready,
    output logic [W-1:0]   rsp_rslt,
    output logic           rsp_taken,
    output logic [OPW-1:0] alu_op,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    input  logic [W-1:0]   alu_rslt,
    input  logic           alu_taken
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           gnt_q, gnt_d;
    logic [OPW-1:0] op_q, op_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   rslt_q, rslt_d;
    logic           taken_q, taken_d;
    logic           rsp0_valid_q, rsp0_valid_d;
    logic           rsp1_valid_q, rsp1_valid_d;
    logic           sel;
    logic           accept;
    logic           rsp_hs;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic           last_q, last_d;
`endif

    // Pick the port to grant while idle
    always_comb begin
        sel = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            sel = 1'b0;
`else
            sel = ~last_q;
`endif
        end else if (req1_valid) begin
            sel = 1'b1;
        end
    end

    assign req0_ready = (state_q == IDLE) && req0_valid && !sel;
    assign req1_ready = (state_q == IDLE) && req1_valid && sel;
    assign accept     = req0_ready || req1_ready;
    assign rsp_hs     = gnt_q ? rsp1_ready : rsp0_ready;

    // Sequence accept -> ALU execute -> hold response until consumed
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        rslt_d       = rslt_q;
        taken_d      = taken_q;
        rsp0_valid_d = rsp0_valid_q;
        rsp1_valid_d = rsp1_valid_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
        last_d       = last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    gnt_d   = sel;
                    op_d    = sel ? req1_op : req0_op;
                    a_d     = sel ? req1_a : req0_a;
                    b_d     = sel ? req1_b : req0_b;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rslt_d       = alu_rslt;
                taken_d      = alu_taken;
                op_d         = '0;
                a_d          = '0;
                b_d          = '0;
                rsp0_valid_d = ~gnt_q;
                rsp1_valid_d = gnt_q;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_hs) begin
                    rsp0_valid_d = 1'b0;
                    rsp1_valid_d = 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
                    last_d       = gnt_q;
`endif
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            gnt_q        <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rslt_q       <= '0;
            taken_q      <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_q       <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rslt_q       <= rslt_d;
            taken_q      <= taken_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_q       <= last_d;
`endif
        end
    end

    assign alu_op     = op_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign rsp_rslt   = rslt_q;
    assign rsp_taken  = taken_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with a stand-in ALU.
// Honours ALU_ARB_FIXED_PRIO_EN in its arbitration model.
`timescale 1ns/1ps
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0] req0_op, req1_op;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [7:0] rsp_rslt;
    logic       rsp_taken;
    logic [2:0] alu_op;
    logic [7:0] alu_a, alu_b, alu_rslt;
    logic       alu_taken;

    alu_arbiter #(.W(8), .OPW(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_rslt(rsp_rslt), .rsp_taken(rsp_taken),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_rslt(alu_rslt), .alu_taken(alu_taken)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         port;
        logic [7:0] rslt;
        bit         taken;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   rsp_mode = 0;
    bit   last_m = 1'b1;

    // Stand-in ALU: {taken, rslt}
    function automatic logic [8:0] alu_f(input logic [2:0] op,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
        logic [7:0] r;
        logic       t;
        t = 1'b0;
        case (op)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b010: r = a + b;
            3'b011: r = a - b;
            3'b100: r = a ^ b;
            3'b101: begin r = a - b; t = (a == 8'h00); end
            3'b110: r = b;
            default: r = a;
        endcase
        return {t, r};
    endfunction

    always_comb {alu_taken, alu_rslt} = alu_f(alu_op, alu_a, alu_b);

    task automatic chk(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    endtask

    always @(posedge clk) cyc++;

    // Response-side ready driver
    always @(posedge clk) begin
        #2;
        case (rsp_mode)
            0: begin rsp0_ready = 1'b1; rsp1_ready = 1'b1; end
            1: begin rsp0_ready = 1'b0; rsp1_ready = 1'b0; end
            default: begin
                rsp0_ready = 1'($urandom_range(0, 1));
                rsp1_ready = 1'($urandom_range(0, 1));
            end
        endcase
    end

    // Monitor: check every presented response against the scoreboard
    bit         hold_p = 1'b0;
    bit         hold_port;
    logic [7:0] hold_rslt;
    bit         hold_taken;
    bit         seen = 1'b0;
    bit         m_port;
    bit         m_hs;
    exp_t       m_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_p = 1'b0;
            seen   = 1'b0;
        end else if (rsp0_valid || rsp1_valid) begin
            m_port = rsp1_valid;
            m_hs   = m_port ? rsp1_ready : rsp0_ready;
            chk(!(rsp0_valid && rsp1_valid), "rsp_onehot",
                {rsp0_valid, rsp1_valid}, 0);
            chk(!req0_ready && !req1_ready, "req_ready_busy",
                {req0_ready, req1_ready}, 0);
            if (hold_p)
                chk(m_port == hold_port && rsp_rslt === hold_rslt &&
                    rsp_taken === hold_taken, "rsp_hold", rsp_rslt, hold_rslt);
            if (exp_q.size() == 0) begin
                chk(1'b0, "rsp_unexpected", m_port, 0);
            end else begin
                if (!seen) begin
                    chk(cyc - exp_q[0].cyc == 2, "rsp_latency",
                        cyc - exp_q[0].cyc, 2);
                    seen = 1'b1;
                end
                if (m_hs) begin
                    m_e = exp_q.pop_front();
                    chk(m_port == m_e.port, "rsp_port", m_port, m_e.port);
                    chk(rsp_rslt === m_e.rslt, "rsp_rslt", rsp_rslt, m_e.rslt);
                    chk(rsp_taken === m_e.taken, "rsp_taken", rsp_taken, m_e.taken);
                    seen = 1'b0;
                end
            end
            hold_p     = !m_hs;
            hold_port  = m_port;
            hold_rslt  = rsp_rslt;
            hold_taken = rsp_taken;
        end else begin
            if (hold_p) chk(1'b0, "rsp_dropped", 0, 1);
            hold_p = 1'b0;
        end
    end

    // Present a request pair, wait for a grant, score the predicted winner
    task automatic issue(input bit v0, input bit v1,
                         input logic [2:0] op0, input logic [7:0] a0, input logic [7:0] b0,
                         input logic [2:0] op1, input logic [7:0] a1, input logic [7:0] b1,
                         output int waited);
        bit         want;
        bit         got;
        logic [8:0] r;
        exp_t       e;
        req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
        want = (v0 && v1) ? 1'b0 : v1;
`else
        want = (v0 && v1) ? ~last_m : v1;
`endif
        r = want ? alu_f(op1, a1, b1) : alu_f(op0, a0, b0);
        waited = 0;
        got = 1'b0;
        while (!got && waited < 40) begin
            @(negedge clk);
            waited++;
            if (req0_ready || req1_ready) got = 1'b1;
        end
        if (!got) begin
            chk(1'b0, "grant_timeout", waited, 40);
        end else begin
            chk(req1_ready === want && req0_ready === !want, "grant_port",
                {req0_ready, req1_ready}, want ? 1 : 2);
            e.port  = want;
            e.rslt  = r[7:0];
            e.taken = r[8];
            e.cyc   = cyc;
            exp_q.push_back(e);
            last_m = want;
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) chk(1'b0, "drain_timeout", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    int         w;
    logic [8:0] ref_r;
    bit         v0, v1;

    initial begin
        rst_n = 1'b0;
        req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
        req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
        rsp0_ready = 0; rsp1_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        chk(!req0_ready && !req1_ready, "rst_ready", {req0_ready, req1_ready}, 0);
        chk(!rsp0_valid && !rsp1_valid, "rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
        chk(rsp_rslt === 8'h00 && rsp_taken === 1'b0, "rst_rslt", {rsp_taken, rsp_rslt}, 0);
        chk(alu_op === 3'b000 && alu_a === 8'h00 && alu_b === 8'h00, "rst_alu",
            {alu_op, alu_a, alu_b}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single add on port 0
        issue(1, 0, 3'b010, 8'h05, 8'h03, 3'b000, 8'h00, 8'h00, w);
        chk(w == 1, "add_grant_wait", w, 1);
        drain();
        chk(rsp_rslt === 8'h08 && rsp_taken === 1'b0, "add_result",
            {rsp_taken, rsp_rslt}, 9'h008);

        // Branch flag on port 1
        issue(0, 1, 3'b000, 8'h00, 8'h00, 3'b101, 8'h00, 8'h11, w);
        drain();
        chk(rsp_taken === 1'b1, "branch_taken", rsp_taken, 1);
        issue(0, 1, 3'b000, 8'h00, 8'h00, 3'b101, 8'h04, 8'h11, w);
        drain();
        chk(rsp_taken === 1'b0, "branch_not_taken", rsp_taken, 0);

        // Both ports contending, responses consumed at once
        for (int i = 0; i < 4; i++) begin
            issue(1, 1, 3'b100, 8'hF0, 8'h0F, 3'b110, 8'($urandom), 8'h5A, w);
            if (i > 0) chk(w == 3, "rr_throughput", w, 3);
        end
        drain();

        // Response backpressure on port 0, port 1 waiting behind it
        rsp_mode = 1;
        issue(1, 0, 3'b011, 8'h40, 8'h01, 3'b000, 8'h00, 8'h00, w);
        ref_r = alu_f(3'b011, 8'h40, 8'h01);
        w = 0;
        while (!rsp0_valid && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk(rsp0_valid === 1'b1, "bp_rsp_valid", rsp0_valid, 1);
        req1_valid = 1'b1; req1_op = 3'b110; req1_a = 8'h00; req1_b = 8'hA5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk(!req0_ready && !req1_ready, "bp_ready_low", {req0_ready, req1_ready}, 0);
            chk(rsp0_valid === 1'b1 && rsp_rslt === ref_r[7:0], "bp_hold",
                rsp_rslt, ref_r[7:0]);
        end
        @(posedge clk);
        #1;
        rsp_mode = 0;
        issue(0, 1, 3'b000, 8'h00, 8'h00, 3'b110, 8'h00, 8'hA5, w);
        chk(w == 2, "bp_next_accept", w, 2);
        drain();

        // Reset while executing
        issue(1, 0, 3'b001, 8'h33, 8'h44, 3'b000, 8'h00, 8'h00, w);
        #3;
        rst_n = 1'b0;
        #1;
        chk(!rsp0_valid && !rsp1_valid, "mid_rst_valid", {rsp0_valid, rsp1_valid}, 0);
        chk(rsp_rslt === 8'h00 && rsp_taken === 1'b0, "mid_rst_rslt",
            {rsp_taken, rsp_rslt}, 0);
        chk(alu_op === 3'b000 && alu_a === 8'h00 && alu_b === 8'h00, "mid_rst_alu",
            {alu_op, alu_a, alu_b}, 0);
        exp_q.delete();
        last_m = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk(!rsp0_valid && !rsp1_valid, "post_rst_no_rsp",
                {rsp0_valid, rsp1_valid}, 0);
        end
        @(posedge clk);
        #1;
        issue(1, 1, 3'b010, 8'h10, 8'h20, 3'b010, 8'h01, 8'h02, w);
        drain();

        // Idle ALU drive
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk(alu_op === 3'b000 && alu_a === 8'h00 && alu_b === 8'h00, "idle_alu",
                {alu_op, alu_a, alu_b}, 0);
            chk(!req0_ready && !req1_ready && !rsp0_valid && !rsp1_valid, "idle_hs",
                {req0_ready, req1_ready, rsp0_valid, rsp1_valid}, 0);
        end
        @(posedge clk);
        #1;

        // Randomised traffic with random response backpressure
        for (int i = 0; i < 60; i++) begin
            rsp_mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            issue(v0, v1, 3'($urandom), 8'($urandom), 8'($urandom),
                  3'($urandom), 8'($urandom), 8'($urandom), w);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        rsp_mode = 0;
        drain();
        chk(exp_q.size() == 0, "final_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
